// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU operations in a FIFO, issues them one at a time and returns
// each result over a valid/ready handshake. Define ALU_SEQ_MULTISHIFT_EN for multi-bit shifts.
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [2:0]               in_sel,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_sel,
    input  logic [WIDTH-1:0]         alu_y,
    input  logic                     alu_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic                     out_nonzero,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       sel;
    } op_t;

`ifdef ALU_SEQ_MULTISHIFT_EN
    typedef enum logic [1:0] {IDLE, ISSUE, SHIFT, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
`endif

    op_t              fifo_mem [DEPTH];
    op_t              head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    state_t           state;
    logic [WIDTH-1:0] res_y;
    logic             res_nz;
    logic             push;
    logic             pop;

    assign in_ready    = (fifo_count != COUNT_FULL);
    assign push        = in_valid && in_ready;
    assign pop         = (state == IDLE) && (fifo_count != '0);
    assign head        = fifo_mem[rd_ptr];
    assign out_y       = res_y;
    assign out_nonzero = res_nz;

    // NOTE: the payload array has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{a: in_a, b: in_b, sel: in_sel};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef ALU_SEQ_MULTISHIFT_EN
    logic [2:0] op_sel;
    logic [4:0] shift_amt;
    logic [4:0] remaining;
    logic       multi_shift;

    // A count of 0 or 1 is a single pass, so only counts of 2+ need the SHIFT state.
    assign multi_shift = ((op_sel == 3'b101) || (op_sel == 3'b110)) && (shift_amt > 5'd1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_y     <= '0;
            res_nz    <= 1'b0;
            out_valid <= 1'b0;
`ifdef ALU_SEQ_MULTISHIFT_EN
            op_sel    <= '0;
            shift_amt <= '0;
            remaining <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a   <= head.a;
                        alu_b   <= head.b;
                        alu_sel <= head.sel;
`ifdef ALU_SEQ_MULTISHIFT_EN
                        op_sel    <= head.sel;
                        shift_amt <= head.b[4:0];
`endif
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_y     <= alu_y;
                    res_nz    <= alu_zero;
                    alu_a     <= '0;
                    alu_b     <= '0;
                    alu_sel   <= '0;
                    out_valid <= 1'b1;
                    state     <= HOLD;
`ifdef ALU_SEQ_MULTISHIFT_EN
                    // Later assignments win: keep the ALU busy and feed the result back.
                    if (multi_shift) begin
                        alu_a     <= alu_y;
                        alu_b     <= alu_b;
                        alu_sel   <= alu_sel;
                        out_valid <= 1'b0;
                        remaining <= shift_amt - 5'd1;
                        state     <= SHIFT;
                    end
`endif
                end
`ifdef ALU_SEQ_MULTISHIFT_EN
                SHIFT: begin
                    res_y     <= alu_y;
                    res_nz    <= alu_zero;
                    alu_a     <= alu_y;
                    remaining <= remaining - 5'd1;
                    if (remaining == 5'd1) begin
                        alu_a     <= '0;
                        alu_b     <= '0;
                        alu_sel   <= '0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
`endif
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed steps followed by a randomized phase checked against
// a queue-based reference model. Honours ALU_SEQ_MULTISHIFT_EN when it is defined.
module tb_alu_op_sequencer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int N_RAND = 40;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_nonzero;
    logic [2:0]       fifo_count;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             nz;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared = 0;
    int   n_mismatched = 0;

    alu_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_y(alu_y), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_nonzero(out_nonzero),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Combinational ALU the sequencer drives; its flag is 1 for a nonzero result.
    always_comb begin
        case (alu_sel)
            3'b001:  alu_y = alu_a + alu_b;
            3'b010:  alu_y = alu_a & alu_b;
            3'b011:  alu_y = alu_a | alu_b;
            3'b100:  alu_y = alu_a ^ alu_b;
            3'b101:  alu_y = alu_a << 1;
            3'b110:  alu_y = alu_a >> 1;
            3'b111:  alu_y = ~(alu_a ^ alu_b);
            default: alu_y = '0;
        endcase
        alu_zero = (alu_y != '0);
    end

    function automatic int shift_count(logic [WIDTH-1:0] b);
        int n;
        n = 1;
`ifdef ALU_SEQ_MULTISHIFT_EN
        n = (b[4:0] == 5'd0) ? 1 : int'(b[4:0]);
`endif
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] ref_result(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                                    logic [2:0] sel);
        case (sel)
            3'd1:    return a + b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << shift_count(b);
            3'd6:    return a >> shift_count(b);
            3'd7:    return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(logic [WIDTH-1:0] b, logic [2:0] sel);
        if (sel == 3'd5 || sel == 3'd6) return 2 + shift_count(b);
        return 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] sel);
        exp_t e;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sel = sel;
        tick();
        in_valid = 1'b0;
        e.y = ref_result(a, b, sel);
        e.nz = (e.y != '0);
        exp_q.push_back(e);
    endtask

    task automatic run_single(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [2:0] sel);
        int k;
        exp_t e;
        out_ready = 1'b1;
        push_op(a, b, sel);
        k = 0;
        while (!out_valid && k < 100) begin
            tick();
            k++;
        end
        e = exp_q.pop_front();
        check({tag, "_latency"}, 64'(k + 1), 64'(ref_latency(b, sel)));
        check({tag, "_y"}, 64'(out_y), 64'(e.y));
        check({tag, "_nz"}, 64'(out_nonzero), 64'(e.nz));
        tick();
        check({tag, "_released"}, 64'(out_valid), 64'd0);
    endtask

    task automatic drain_one(input string tag, output int k);
        exp_t e;
        k = 0;
        while (!out_valid && k < 100) begin
            tick();
            k++;
        end
        e = exp_q.pop_front();
        check({tag, "_y"}, 64'(out_y), 64'(e.y));
        check({tag, "_nz"}, 64'(out_nonzero), 64'(e.nz));
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        int   k;
        int   valid_seen;
        int   issued;
        int   received;
        int   cyc;
        exp_t e;

        reset = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sel = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_out_nonzero", 64'(out_nonzero), 64'd0);
        check("rst_alu", 64'({alu_a, alu_b[0], alu_sel}), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        reset = 1'b0;
        tick();

        // add 5+7: cycle-by-cycle view of the pipeline
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = 5;
        in_b = 7;
        in_sel = 3'b001;
        tick();
        in_valid = 1'b0;
        check("add_t1_count", 64'(fifo_count), 64'd1);
        check("add_t1_alu_sel", 64'(alu_sel), 64'd0);
        check("add_t1_out_valid", 64'(out_valid), 64'd0);
        tick();
        check("add_t2_alu_sel", 64'(alu_sel), 64'd1);
        check("add_t2_alu_a", 64'(alu_a), 64'd5);
        check("add_t2_alu_b", 64'(alu_b), 64'd7);
        check("add_t2_out_valid", 64'(out_valid), 64'd0);
        tick();
        check("add_t3_out_valid", 64'(out_valid), 64'd1);
        check("add_t3_out_y", 64'(out_y), 64'd12);
        check("add_t3_nz", 64'(out_nonzero), 64'd1);
        check("add_t3_alu_sel", 64'(alu_sel), 64'd0);
        tick();
        check("add_t4_out_valid", 64'(out_valid), 64'd0);

        run_single("and_zero", 32'h0000_F0F0, 32'h0000_0F0F, 3'b010);
        run_single("sel_zero", 32'hDEAD_BEEF, 32'h1234_5678, 3'b000);
        run_single("xnor", 32'h1234_5678, 32'h1234_5678, 3'b111);
        run_single("shl_b4", 32'd1, 32'd4, 3'b101);
        run_single("shr_b0", 32'h8000_0000, 32'd0, 3'b110);
        run_single("shr_b31", 32'h8000_0000, 32'd31, 3'b110);

        // fill the FIFO behind a stalled output
        out_ready = 1'b0;
        push_op(32'd100, 32'd23, 3'b001);
        push_op(32'hFF00_FF00, 32'h0F0F_0F0F, 3'b100);
        push_op(32'h0000_0011, 32'h0000_1100, 3'b011);
        push_op(32'hAAAA_AAAA, 32'h5555_5555, 3'b111);
        push_op(32'hFFFF_0000, 32'h00FF_FF00, 3'b010);
        check("full_count", 64'(fifo_count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_a = 32'd1;
        in_b = 32'd1;
        in_sel = 3'b001;
        tick();
        tick();
        in_valid = 1'b0;
        check("stall_count", 64'(fifo_count), 64'd4);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("hold_out_valid", 64'(out_valid), 64'd1);
        check("hold_out_y_stable", 64'(out_y), 64'(exp_q[0].y));
        out_ready = 1'b1;
        drain_one("full_r1", k);
        check("after_r1_count", 64'(fifo_count), 64'd4);
        tick();
        check("reopen_in_ready", 64'(in_ready), 64'd1);
        check("reopen_count", 64'(fifo_count), 64'd3);
        drain_one("full_r2", k);
        for (int i = 3; i <= 5; i++) begin
            drain_one($sformatf("full_r%0d", i), k);
            check($sformatf("throughput_r%0d", i), 64'(k + 1), 64'd3);
        end
        check("drained_count", 64'(fifo_count), 64'd0);

        // reset while an op is in flight and two more are queued
        out_ready = 1'b0;
        push_op(32'd3, 32'd5, 3'b101);
        push_op(32'd7, 32'd1, 3'b001);
        push_op(32'd9, 32'd2, 3'b100);
        check("pre_rst_count", 64'(fifo_count), 64'd2);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_alu_sel", 64'(alu_sel), 64'd0);
        check("midrst_alu_a", 64'(alu_a), 64'd0);
        check("midrst_out_y", 64'(out_y), 64'd0);
        check("midrst_count", 64'(fifo_count), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) valid_seen++;
        end
        check("post_rst_no_result", 64'(valid_seen), 64'd0);

        // randomized traffic with random backpressure
        issued = 0;
        received = 0;
        cyc = 0;
        while (received < N_RAND && cyc < 5000) begin
            if (issued < N_RAND && ($urandom % 2) == 0) begin
                in_valid = 1'b1;
                in_a = $urandom;
                in_b = (($urandom % 2) == 0) ? 32'($urandom % 8) : $urandom;
                in_sel = 3'($urandom % 8);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (($urandom % 4) != 0);
            if (in_valid && in_ready) begin
                e.y = ref_result(in_a, in_b, in_sel);
                e.nz = (e.y != '0);
                exp_q.push_back(e);
                issued++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("rand%0d_unexpected", received), 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rand%0d_y", received), 64'(out_y), 64'(e.y));
                    check($sformatf("rand%0d_nz", received), 64'(out_nonzero), 64'(e.nz));
                end
                received++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_received", 64'(received), 64'(N_RAND));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
